// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: splits 64-bit fetch beats into 32-bit instructions for decode.
// Optional same-cycle empty-queue bypass is enabled with `define FETCH_QUEUE_BYPASS_EN.
module inst_fetch_queue #(
    parameter int DEPTH = 8,
    parameter int PC_W  = 64
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [PC_W-1:0] in_pc,
    input  logic [63:0]     in_data,
    input  logic            in_fault,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [31:0]     out_instr,
    output logic            out_fault
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic [PC_W-1:0] pc_mem    [DEPTH];
    logic [31:0]     instr_mem [DEPTH];
    logic            fault_mem [DEPTH];

    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;

    logic [PC_W-1:0] hold_pc;
    logic [31:0]     hold_instr;
    logic            hold_fault;

    logic            queue_empty, push_acc, q_pop;
    logic            bypass_valid, bypass_take;
    logic [PC_W-1:0] base_pc, first_pc, second_pc;
    logic [31:0]     first_instr, second_instr;
    logic            first_fault, has_second;
    logic [1:0]      n_wr;
    logic [PC_W-1:0] w0_pc, w1_pc;
    logic [31:0]     w0_instr, w1_instr;
    logic            w0_fault, w1_fault;

    assign queue_empty = (count == '0);
    assign in_ready    = (CW'(DEPTH) - count) >= CW'(2);
    assign push_acc    = in_valid & in_ready & ~flush;
    assign q_pop       = ~queue_empty & out_ready & ~flush;

    // Decode the beat into its first (and optional second) instruction
    always_comb begin
        base_pc      = in_pc & ~PC_W'(3);
        first_pc     = base_pc;
        second_pc    = base_pc + PC_W'(4);
        first_fault  = in_fault;
        has_second   = ~in_fault & ~in_pc[2];
        second_instr = in_data[63:32];
        if (in_fault)
            first_instr = NOP_INSTR;
        else if (in_pc[2])
            first_instr = in_data[63:32];
        else
            first_instr = in_data[31:0];
    end

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass_valid = queue_empty & push_acc;
    assign bypass_take  = bypass_valid & out_ready;
`else
    assign bypass_valid = 1'b0;
    assign bypass_take  = 1'b0;
`endif

    // A bypassed first instruction is never stored; the second slot moves up to write port 0
    always_comb begin
        n_wr     = 2'd0;
        w0_pc    = first_pc;
        w0_instr = first_instr;
        w0_fault = first_fault;
        w1_pc    = second_pc;
        w1_instr = second_instr;
        w1_fault = 1'b0;
        if (bypass_take) begin
            n_wr     = has_second ? 2'd1 : 2'd0;
            w0_pc    = second_pc;
            w0_instr = second_instr;
            w0_fault = 1'b0;
        end else if (push_acc) begin
            n_wr = has_second ? 2'd2 : 2'd1;
        end
    end

    always_comb begin
        out_valid = ~queue_empty | bypass_valid;
        if (!queue_empty) begin
            out_pc    = pc_mem[rd_ptr];
            out_instr = instr_mem[rd_ptr];
            out_fault = fault_mem[rd_ptr];
        end else if (bypass_valid) begin
            out_pc    = first_pc;
            out_instr = first_instr;
            out_fault = first_fault;
        end else begin
            out_pc    = hold_pc;
            out_instr = hold_instr;
            out_fault = hold_fault;
        end
    end

    always_ff @(posedge clk) begin
        if (n_wr != 2'd0) begin
            pc_mem[wr_ptr]    <= w0_pc;
            instr_mem[wr_ptr] <= w0_instr;
            fault_mem[wr_ptr] <= w0_fault;
        end
        if (n_wr == 2'd2) begin
            pc_mem[wr_ptr + AW'(1)]    <= w1_pc;
            instr_mem[wr_ptr + AW'(1)] <= w1_instr;
            fault_mem[wr_ptr + AW'(1)] <= w1_fault;
        end
    end

    // Flush wins over any push or pop; hold regs keep the last head visible once empty
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            hold_pc    <= '0;
            hold_instr <= '0;
            hold_fault <= 1'b0;
        end else begin
            if (out_valid) begin
                hold_pc    <= out_pc;
                hold_instr <= out_instr;
                hold_fault <= out_fault;
            end
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                rd_ptr <= rd_ptr + AW'(q_pop);
                wr_ptr <= wr_ptr + AW'(n_wr);
                count  <= count + CW'(n_wr) - CW'(q_pop);
            end
        end
    end

endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
- Producer-side buffer feeding the instruction decoder.
- Accepts 64-bit fetch beats (two RV64 instruction slots) from the I-side memory interface, splits them into single 32-bit instructions with their PCs, and presents one instruction per cycle to decode over a valid/ready handshake.
- Supports pipeline flush on redirect (branch, jump, exception).

Parameters:
- DEPTH, 8, number of instruction entries; power of 2, minimum 4.
- PC_W, 64, PC width.

Ports:
- clk  in  1  core clock
- resetn  in  1  asynchronous active-low reset
- flush  in  1  discard all buffered and incoming instructions this cycle
- in_valid  in  1  fetch beat valid
- in_ready  out  1  queue can accept a full beat
- in_pc  in  PC_W  address of the beat; bit 2 selects the starting slot
- in_data  in  64  slot0 = [31:0] at pc&~7, slot1 = [63:32] at (pc&~7)+4
- in_fault  in  1  access fault on this beat
- out_valid  out  1  head instruction valid
- out_ready  in  1  decoder accepts head
- out_pc  out  PC_W  PC of head instruction
- out_instr  out  32  head instruction word
- out_fault  out  1  head carries fetch fault

Behaviour:
- Reset (resetn low, asynchronous):
  - Read/write pointers and count cleared.
  - out_valid=0, in_ready=1, out_pc=0, out_instr=0, out_fault=0.
  - Entry storage need not be reset.
- Storage:
  - Circular buffer of DEPTH entries {pc, instr, fault}.
  - Pointers have width log2(DEPTH) and wrap modulo DEPTH.
  - count has width log2(DEPTH)+1, range 0..DEPTH.
- in_ready = (DEPTH - count) >= 2. Registered count only; it does not depend on the same-cycle pop.
- Accepting a beat (push when in_valid & in_ready & ~flush):
  - in_pc[2]=0, in_fault=0: push 2 entries, slot0 then slot1. PCs are in_pc and in_pc+4.
  - in_pc[2]=1, in_fault=0: push 1 entry, slot1 at in_pc.
  - in_fault=1: push exactly 1 entry with instr=32'h00000013 (NOP encoding), fault=1, pc=in_pc. Upper slot discarded.
  - in_pc[1:0] ignored (treated as 0).
- Pop when out_valid & out_ready & ~flush: read pointer +1, count -1.
- Simultaneous push and pop in one cycle: count += pushed - 1. Legal at any occupancy.
- out_valid = (count != 0). out_pc, out_instr and out_fault are driven combinationally from the head entry. They hold stable while out_valid & ~out_ready.
- Latency: an instruction accepted at edge N is visible at the output after edge N (one cycle). The head is never bypassed from the input.
- Flush:
  - Highest priority. At the next edge, count=0 and pointers=0.
  - The beat presented in the flush cycle is dropped even if in_ready=1.
  - A pop in the flush cycle is not counted as consumed.
  - out_valid=0 the cycle after flush.
- Full: count=DEPTH-1 or DEPTH gives in_ready=0. No overflow is possible.
- Empty: out_valid=0. out_* hold the last head value and must not be consumed.
- Ordering: strict program order. The upper slot of the same beat never overtakes the lower slot.

Optional Feature:
- Macro: FETCH_QUEUE_BYPASS_EN.
- Defined:
  - When count=0, a beat accepted this cycle drives out_valid=1 combinationally with its first instruction (same-cycle bypass).
  - If out_ready is also 1, that instruction is not written. Only the second slot (if any) is pushed.
  - Flush still overrides: out_valid=0 during flush.
- Undefined: one-cycle latency as specified above, with no combinational in->out path.

Test Plan:
- Reset, then push beat pc=0x80000000, data=0x00100093_00000013 with out_ready=1 -> next cycles out (0x80000000, 0x00000013), then (0x80000004, 0x00100093). out_valid=0 after.
- Push pc=0x80000004 data=0xAAAAAAAA_BBBBBBBB -> single entry out_pc=0x80000004, out_instr=0xAAAAAAAA.
- Push with in_fault=1 pc=0x80000010 -> one entry, out_instr=0x00000013, out_fault=1; upper slot never appears.
- out_ready=0, push 4 aligned beats (DEPTH=8) -> count=8 and in_ready=0 after the 4th. Head stable at the first PC. Release out_ready -> 8 instructions in PC order; in_ready returns when count<=6.
- Queue half full, assert flush together with in_valid and out_ready -> next cycle out_valid=0, count=0, dropped beat never emitted. A new beat after flush is emitted first.
- FETCH_QUEUE_BYPASS_EN defined, empty queue, push aligned beat with out_ready=1 -> slot0 on the output the same cycle, slot1 the next cycle; undefined build shows slot0 one cycle later.
